conversor_decimal_binario: RTL and testbench
============================================

CONVERSOR_DECIMAL_BINARIO -- requirements
Module: conversor_decimal_binario

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles before a key level is accepted (10 ms at 50 MHz).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 CLOCK_50  in  1  system clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 SW  in  [3:0]  raw digit value from switches, sampled only on an accepted ENTER press.
REQ-006 KEY  in  [1:0]  raw active-low pushbuttons, asynchronous to CLOCK_50; KEY[0] = ENTER, KEY[1] = CLEAR.
REQ-007 valor  out  [6:0]  binary value of the entered two-digit decimal number, 0..99.
REQ-008 valido  out  1  high while valor holds a completed entry.
REQ-009 pulso  out  1  one-cycle strobe when an entry completes.
REQ-010 erro  out  1  high while in state ERRO.
REQ-011 HEX1, HEX0  out  [0:6] each  active-low segments a..g; HEX1 = tens, HEX0 = units.

Function
REQ-012 Each KEY bit SHALL pass through a 2-flop synchronizer, then a per-key debounce counter.
REQ-013 Debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-014 Press event = debounced level 1->0, exactly one cycle wide; release produces no event.
REQ-015 FSM states: ESPERA_DEZENA, ESPERA_UNIDADE, PRONTO, ERRO.
REQ-016 ESPERA_DEZENA + ENTER: SW<=9 -> latch dezena=SW, go ESPERA_UNIDADE; SW>9 -> go ERRO.
REQ-017 ESPERA_UNIDADE + ENTER: SW<=9 -> latch unidade=SW, go PRONTO; SW>9 -> go ERRO, discard dezena.
REQ-018 PRONTO + ENTER: treated as a new tens entry exactly as in REQ-016; valor and valido clear on that same transition.
REQ-019 ERRO + ENTER: go ESPERA_DEZENA, no capture.
REQ-020 CLEAR event in any state: go ESPERA_DEZENA, clear dezena, unidade, valor, valido. CLEAR wins over a same-cycle ENTER.
REQ-021 valor = dezena*10 + unidade, computed without a multiplier (shift-and-add, (d<<3)+(d<<1)+u) in 7 bits; no overflow possible (max 99).
REQ-022 valor and valido SHALL update in the clock edge that enters PRONTO; pulso high for exactly that following cycle.
REQ-023 Latency: raw KEY[0] low edge to state change = 2 sync cycles + DEBOUNCE_CYCLES + 1 cycle; a held key produces one event only.
REQ-024 Outside PRONTO, valor = 0 and valido = 0.
REQ-025 Display: digits use the team's standard active-low code (0 = 0000001, 1 = 1001111, ..., 9 = 0000100); blank = 1111111.
REQ-026 HEX1 shows dezena once latched, otherwise blank; HEX0 shows unidade in PRONTO, otherwise blank.
REQ-027 In ERRO: HEX1 = "E" (0110000), HEX0 = blank, erro = 1.
REQ-028 Every case statement SHALL have a default (no latches); unused state encodings SHALL recover to ESPERA_DEZENA.

Reset
REQ-029 reset asserted: state = ESPERA_DEZENA; dezena = unidade = 0; valor = 0; valido = pulso = erro = 0; HEX1 = HEX0 = 1111111; synchronizers and debounced levels = 1 (released); counters = 0.
REQ-030 Reset mid-entry or mid-debounce SHALL abandon the entry; a key still held at deassertion SHALL first be seen as released, so no event is generated until it is released and pressed again.

Verification (DEBOUNCE_CYCLES = 4)
REQ-031 SW=4, ENTER; SW=7, ENTER -> pulso one cycle, valor=47, valido=1, HEX1=1001100, HEX0=0001101.
REQ-032 SW=9, ENTER twice -> valor=99 (1100011). SW=0, ENTER twice -> valor=0, valido=1.
REQ-033 SW=12 on first ENTER -> erro=1, HEX1=0110000. Next ENTER -> ESPERA_DEZENA, erro=0, HEX all blank.
REQ-034 KEY[0] bounces low/high every 2 cycles for 20 cycles, then held low -> exactly one event, DEBOUNCE_CYCLES after it settles.
REQ-035 In PRONTO (valor=47), ENTER and CLEAR asserted in the same cycle -> ESPERA_DEZENA, valor=0, no tens captured.
REQ-036 reset pulsed between tens and units entry -> all outputs at reset values; a subsequent full entry 2,5 -> valor=25.

Source files
------------

// File: rtl/conversor_decimal_binario.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : conversor_decimal_binario                                  |
// | Brief   : two-digit decimal entry via switches/keys -> binary value  |
// |           with debounced keys and 7-segment display of the digits.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module conversor_decimal_binario #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [3:0] SW,
  input  logic [1:0] KEY,
  output logic [6:0] valor,
  output logic       valido,
  output logic       pulso,
  output logic       erro,
  output logic [0:6] HEX1,
  output logic [0:6] HEX0
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [1:0] ESPERA_DEZENA  = 2'd0;
  localparam logic [1:0] ESPERA_UNIDADE = 2'd1;
  localparam logic [1:0] PRONTO         = 2'd2;
  localparam logic [1:0] ERRO           = 2'd3;

  localparam logic [0:6] c_seg_blank = 7'b1111111;
  localparam logic [0:6] c_seg_e     = 7'b0110000;

  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_vld;
  logic [1:0] w_press;

  logic [1:0] r_state;
  logic [3:0] r_dezena;
  logic [3:0] r_unidade;
  logic [6:0] r_valor;
  logic       r_valido;
  logic       r_pulso;
  logic [6:0] w_valor;
  logic       w_enter;
  logic       w_clear;
  logic       w_sw_ok;

  // r_vld marks when r_sync2 holds a real sample rather than its reset value
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
      r_vld   <= 2'b00;
    end else begin
      r_sync1 <= KEY;
      r_sync2 <= r_sync1;
      r_vld   <= {r_vld[0], 1'b1};
    end
  end

  generate
    for (genvar k = 0; k < 2; k++) begin : g_key
      logic [CNT_W-1:0] r_cnt;
      logic             r_deb;
      logic             r_deb_d;
      logic             r_armed;

      // A key held through reset is not armed until it is seen released.
      always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
          r_cnt   <= '0;
          r_deb   <= 1'b1;
          r_deb_d <= 1'b1;
          r_armed <= 1'b0;
        end else begin
          r_deb_d <= r_deb;
          if (r_vld[1] && r_sync2[k])
            r_armed <= 1'b1;
          if (r_sync2[k] != r_deb) begin
            if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
              r_deb <= r_sync2[k];
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_cnt <= '0;
          end
        end
      end

      assign w_press[k] = r_armed & r_deb_d & ~r_deb;
    end
  endgenerate

  assign w_enter = w_press[0];
  assign w_clear = w_press[1];
  assign w_sw_ok = (SW <= 4'd9);
  assign w_valor = ({3'b000, r_dezena} << 3) + ({3'b000, r_dezena} << 1) + {3'b000, SW};

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state   <= ESPERA_DEZENA;
      r_dezena  <= 4'd0;
      r_unidade <= 4'd0;
      r_valor   <= 7'd0;
      r_valido  <= 1'b0;
      r_pulso   <= 1'b0;
    end else begin
      r_pulso <= 1'b0;
      if (w_clear) begin
        r_state   <= ESPERA_DEZENA;
        r_dezena  <= 4'd0;
        r_unidade <= 4'd0;
        r_valor   <= 7'd0;
        r_valido  <= 1'b0;
      end else if (w_enter) begin
        case (r_state)
          ESPERA_DEZENA, PRONTO: begin
            r_valor   <= 7'd0;
            r_valido  <= 1'b0;
            r_unidade <= 4'd0;
            if (w_sw_ok) begin
              r_dezena <= SW;
              r_state  <= ESPERA_UNIDADE;
            end else begin
              r_dezena <= 4'd0;
              r_state  <= ERRO;
            end
          end
          ESPERA_UNIDADE: begin
            if (w_sw_ok) begin
              r_unidade <= SW;
              r_valor   <= w_valor;
              r_valido  <= 1'b1;
              r_pulso   <= 1'b1;
              r_state   <= PRONTO;
            end else begin
              r_dezena <= 4'd0;
              r_state  <= ERRO;
            end
          end
          ERRO:    r_state <= ESPERA_DEZENA;
          default: r_state <= ESPERA_DEZENA;
        endcase
      end
    end
  end

  function automatic logic [0:6] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001101;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = c_seg_blank;
    endcase
  endfunction

  always_comb begin
    HEX1 = c_seg_blank;
    HEX0 = c_seg_blank;
    case (r_state)
      ESPERA_UNIDADE: HEX1 = seg7(r_dezena);
      PRONTO: begin
        HEX1 = seg7(r_dezena);
        HEX0 = seg7(r_unidade);
      end
      ERRO:    HEX1 = c_seg_e;
      default: ;
    endcase
  end

  assign valor  = r_valor;
  assign valido = r_valido;
  assign pulso  = r_pulso;
  assign erro   = (r_state == ERRO);

endmodule
`default_nettype wire

// File: tb/tb_conversor_decimal_binario.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_conversor_decimal_binario                               |
// | Brief   : directed self-checking bench, DEBOUNCE_CYCLES = 4.         |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_conversor_decimal_binario;

  localparam logic [6:0] BLANK = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sw  = 4'd0;
  logic [1:0] key = 2'b11;
  logic [6:0] valor;
  logic       valido;
  logic       pulso;
  logic       erro;
  logic [0:6] hex1;
  logic [0:6] hex0;

  int total = 0;
  int bad   = 0;
  int pcount = 0;

  conversor_decimal_binario #(.DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50(clk), .reset(rst), .SW(sw), .KEY(key),
    .valor(valor), .valido(valido), .pulso(pulso), .erro(erro),
    .HEX1(hex1), .HEX0(hex0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      if (pulso) pcount++;
    end
  endtask

  // drive on the falling edge, hold long enough for press and release to debounce
  task automatic press(input int k, input logic [3:0] v);
    sw = v;
    key[k] = 1'b0;
    cycles(12);
    key[k] = 1'b1;
    cycles(12);
  endtask

  initial begin
    int n;
    logic seen;
    @(negedge clk);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(3);
    check("rst_valor", 32'(valor), 32'd0);
    check("rst_valido", 32'(valido), 32'd0);
    check("rst_pulso", 32'(pulso), 32'd0);
    check("rst_erro", 32'(erro), 32'd0);
    check("rst_hex1", 32'(hex1), 32'(BLANK));
    check("rst_hex0", 32'(hex0), 32'(BLANK));

    pcount = 0;
    press(0, 4'd4);
    check("t4_hex1", 32'(hex1), 32'(7'b1001100));
    check("t4_hex0", 32'(hex0), 32'(BLANK));
    check("t4_valido", 32'(valido), 32'd0);
    press(0, 4'd7);
    check("47_pulse", 32'(pcount), 32'd1);
    check("47_valor", 32'(valor), 32'd47);
    check("47_valido", 32'(valido), 32'd1);
    check("47_hex1", 32'(hex1), 32'(7'b1001100));
    check("47_hex0", 32'(hex0), 32'(7'b0001101));

    press(0, 4'd9);
    check("pronto_new_valor", 32'(valor), 32'd0);
    check("pronto_new_valido", 32'(valido), 32'd0);
    check("pronto_new_hex1", 32'(hex1), 32'(7'b0000100));
    check("pronto_new_hex0", 32'(hex0), 32'(BLANK));
    press(0, 4'd9);
    check("99_valor", 32'(valor), 32'(7'b1100011));

    press(0, 4'd0);
    press(0, 4'd0);
    check("00_valor", 32'(valor), 32'd0);
    check("00_valido", 32'(valido), 32'd1);
    check("00_hex0", 32'(hex0), 32'(7'b0000001));

    press(0, 4'd12);
    check("e_tens_erro", 32'(erro), 32'd1);
    check("e_tens_hex1", 32'(hex1), 32'(7'b0110000));
    check("e_tens_hex0", 32'(hex0), 32'(BLANK));
    check("e_tens_valido", 32'(valido), 32'd0);
    press(0, 4'd3);
    check("e_exit_erro", 32'(erro), 32'd0);
    check("e_exit_hex1", 32'(hex1), 32'(BLANK));
    check("e_exit_hex0", 32'(hex0), 32'(BLANK));

    press(0, 4'd1);
    press(0, 4'd10);
    check("e_units_erro", 32'(erro), 32'd1);
    press(0, 4'd0);
    check("e_units_exit", 32'(erro), 32'd0);

    // bounce: 2 low / 2 high, five periods, then held low
    sw = 4'd3;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      key[0] = 1'b0;
      cycles(2);
      key[0] = 1'b1;
      cycles(2);
      if (hex1 !== BLANK) seen = 1'b1;
    end
    cycles(8);
    if (hex1 !== BLANK) seen = 1'b1;
    check("bounce_no_event", 32'(seen), 32'd0);
    key[0] = 1'b0;
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (hex1 !== BLANK) break;
    end
    check("bounce_latency", 32'(n), 32'd7);
    cycles(20);
    check("held_one_event", 32'(hex1), 32'(7'b0000110));
    key[0] = 1'b1;
    cycles(12);
    pcount = 0;
    press(0, 4'd5);
    check("35_valor", 32'(valor), 32'd35);
    press(1, 4'd5);
    check("clear_hex1", 32'(hex1), 32'(BLANK));
    check("clear_valor", 32'(valor), 32'd0);

    press(0, 4'd4);
    press(0, 4'd7);
    check("47b_valor", 32'(valor), 32'd47);
    pcount = 0;
    sw = 4'd5;
    key = 2'b00;
    cycles(12);
    key = 2'b11;
    cycles(12);
    check("both_hex1", 32'(hex1), 32'(BLANK));
    check("both_valor", 32'(valor), 32'd0);
    check("both_valido", 32'(valido), 32'd0);
    check("both_pulse", 32'(pcount), 32'd0);

    press(0, 4'd2);
    check("mid_hex1", 32'(hex1), 32'(7'b0010010));
    rst = 1'b1;
    #3;
    check("mid_rst_hex1", 32'(hex1), 32'(BLANK));
    check("mid_rst_valor", 32'(valor), 32'd0);
    check("mid_rst_erro", 32'(erro), 32'd0);
    cycles(2);
    rst = 1'b0;
    cycles(2);
    press(0, 4'd2);
    press(0, 4'd5);
    check("25_valor", 32'(valor), 32'd25);
    check("25_hex0", 32'(hex0), 32'(7'b0100100));

    // key held through reset must be released before it can act
    sw = 4'd6;
    key[0] = 1'b0;
    cycles(3);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(20);
    check("held_rst_hex1", 32'(hex1), 32'(BLANK));
    key[0] = 1'b1;
    cycles(12);
    press(0, 4'd6);
    check("after_rel_hex1", 32'(hex1), 32'(7'b0100000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
